// File: rtl/qrs_peak_search.sv
// Sample-stream front end of the QRS detector: counts samples, tracks the init-phase maximum,
// then finds each supra-threshold excursion and reports its peak before a refractory hold-off.
module qrs_peak_search #(
    parameter int DATA_WIDTH  = 11,
    parameter int CTR_WIDTH   = 24,
    parameter int QRS_WIN     = 36,
    parameter int REFRACT_LEN = 72
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_ce,
    input  logic signed [DATA_WIDTH-1:0] i_sample,
    input  logic                         i_sample_valid,
    input  logic                         i_search_en,
    input  logic        [DATA_WIDTH-1:0] i_qrs_threshold,
    output logic        [CTR_WIDTH-1:0]  o_ctr,
    output logic signed [DATA_WIDTH-1:0] o_abs_diff_short_max,
    output logic                         o_abs_diff_short_valid,
    output logic                         o_extremum_found,
    output logic        [CTR_WIDTH-1:0]  o_peak_ctr,
    output logic        [1:0]            o_dbg_state
);

    localparam int WIN_W = $clog2(QRS_WIN + 1);
    localparam int REF_W = $clog2(REFRACT_LEN + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ABOVE   = 2'd1,
        S_REFRACT = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    started_q, started_d;
    logic [CTR_WIDTH-1:0]    ctr_q, ctr_d;
    logic [DATA_WIDTH-1:0]   max_q, max_d;
    logic                    valid_q, valid_d;
    logic                    found_q, found_d;
    logic [CTR_WIDTH-1:0]    peak_ctr_q, peak_ctr_d;
    logic [DATA_WIDTH-1:0]   peak_q, peak_d;
    logic [CTR_WIDTH-1:0]    peak_idx_q, peak_idx_d;
    logic [WIN_W-1:0]        win_q, win_d;
    logic [REF_W-1:0]        ref_q, ref_d;

    logic                    accept;
    logic [DATA_WIDTH-1:0]   samp;

    assign accept = i_ce & i_sample_valid;
    // Negative differences carry no peak information; treat them as zero.
    assign samp   = i_sample[DATA_WIDTH-1] ? '0 : $unsigned(i_sample);

    always_comb begin
        state_d    = state_q;
        started_d  = started_q | i_search_en;
        ctr_d      = ctr_q;
        max_d      = max_q;
        valid_d    = valid_q;
        found_d    = 1'b0;
        peak_ctr_d = peak_ctr_q;
        peak_d     = peak_q;
        peak_idx_d = peak_idx_q;
        win_d      = win_q;
        ref_d      = ref_q;

        if (accept) begin
            ctr_d   = ctr_q + CTR_WIDTH'(1);
            valid_d = 1'b1;
            if (!started_d && (samp > max_q)) begin
                max_d = samp;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (accept && started_d && i_search_en && (samp > i_qrs_threshold)) begin
                    state_d    = S_ABOVE;
                    peak_d     = samp;
                    peak_idx_d = ctr_q;
                    win_d      = WIN_W'(1);
                end
            end
            S_ABOVE: begin
                if (!i_search_en) begin
                    state_d = S_IDLE;
                end else if (accept) begin
                    if (samp > peak_q) begin
                        peak_d     = samp;
                        peak_idx_d = ctr_q;
                    end
                    win_d = win_q + WIN_W'(1);
                    // Falling below threshold and window exhaustion may coincide; one detection either way.
                    if ((samp <= i_qrs_threshold) || (win_d >= WIN_W'(QRS_WIN))) begin
                        state_d    = S_REFRACT;
                        ref_d      = '0;
                        found_d    = 1'b1;
                        max_d      = peak_d;
                        peak_ctr_d = peak_idx_d;
                    end
                end
            end
            S_REFRACT: begin
                if (accept) begin
                    if ((ref_q + REF_W'(1)) >= REF_W'(REFRACT_LEN)) begin
                        state_d = S_IDLE;
                        ref_d   = '0;
                    end else begin
                        ref_d = ref_q + REF_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            started_q  <= 1'b0;
            ctr_q      <= '0;
            max_q      <= '0;
            valid_q    <= 1'b0;
            found_q    <= 1'b0;
            peak_ctr_q <= '0;
            peak_q     <= '0;
            peak_idx_q <= '0;
            win_q      <= '0;
            ref_q      <= '0;
        end else begin
            state_q    <= state_d;
            started_q  <= started_d;
            ctr_q      <= ctr_d;
            max_q      <= max_d;
            valid_q    <= valid_d;
            found_q    <= found_d;
            peak_ctr_q <= peak_ctr_d;
            peak_q     <= peak_d;
            peak_idx_q <= peak_idx_d;
            win_q      <= win_d;
            ref_q      <= ref_d;
        end
    end

    assign o_ctr                  = ctr_q;
    assign o_abs_diff_short_max   = $signed(max_q);
    assign o_abs_diff_short_valid = valid_q;
    assign o_extremum_found       = found_q;
    assign o_peak_ctr             = peak_ctr_q;
    assign o_dbg_state            = state_q;

endmodule

// File: tb/tb_qrs_peak_search.sv
// Directed bench for qrs_peak_search: short window/refractory instance plus a 4-bit counter
// instance sharing the same stimulus for the wrap check.
module tb_qrs_peak_search;

    logic               clk = 1'b0;
    logic               rst;
    logic               ce;
    logic signed [10:0] sample;
    logic               sample_valid;
    logic               search_en;
    logic [10:0]        thr;

    logic [23:0]        ctr;
    logic signed [10:0] amax;
    logic               avalid;
    logic               found;
    logic [23:0]        peak_ctr;
    logic [1:0]         state;

    logic [3:0]         w_ctr;
    logic signed [10:0] w_amax;
    logic               w_avalid;
    logic               w_found;
    logic [3:0]         w_peak_ctr;
    logic [1:0]         w_state;

    int checks   = 0;
    int failures = 0;
    int exp_ctr  = 0;

    qrs_peak_search #(.DATA_WIDTH(11), .CTR_WIDTH(24), .QRS_WIN(4), .REFRACT_LEN(3)) dut (
        .i_clk(clk), .i_rst(rst), .i_ce(ce), .i_sample(sample), .i_sample_valid(sample_valid),
        .i_search_en(search_en), .i_qrs_threshold(thr),
        .o_ctr(ctr), .o_abs_diff_short_max(amax), .o_abs_diff_short_valid(avalid),
        .o_extremum_found(found), .o_peak_ctr(peak_ctr), .o_dbg_state(state)
    );

    qrs_peak_search #(.DATA_WIDTH(11), .CTR_WIDTH(4), .QRS_WIN(4), .REFRACT_LEN(3)) dut_w (
        .i_clk(clk), .i_rst(rst), .i_ce(ce), .i_sample(sample), .i_sample_valid(sample_valid),
        .i_search_en(search_en), .i_qrs_threshold(thr),
        .o_ctr(w_ctr), .o_abs_diff_short_max(w_amax), .o_abs_diff_short_valid(w_avalid),
        .o_extremum_found(w_found), .o_peak_ctr(w_peak_ctr), .o_dbg_state(w_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One accepted sample; returns at the negedge after the capturing posedge.
    task automatic send(input logic signed [10:0] s);
        @(negedge clk);
        sample       = s;
        sample_valid = 1'b1;
        ce           = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        exp_ctr++;
    endtask

    task automatic idle();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; ce = 1'b0; sample = '0; sample_valid = 1'b0; search_en = 1'b0; thr = '0;
        repeat (3) @(negedge clk);
        chk("rst_ctr", 32'(ctr), 0);
        chk("rst_max", 32'(amax), 0);
        chk("rst_valid", 32'(avalid), 0);
        chk("rst_found", 32'(found), 0);
        chk("rst_peak_ctr", 32'(peak_ctr), 0);
        chk("rst_state", 32'(state), 0);
        rst = 1'b0;
        idle();

        // Init phase: running maximum, negative clamped
        send(11'sd5);
        chk("init_max5", 32'(amax), 5);
        chk("init_valid", 32'(avalid), 1);
        send(11'sd12);
        chk("init_max12", 32'(amax), 12);
        send(-11'sd3);
        chk("init_max_neg", 32'(amax), 12);
        send(11'sd9);
        chk("init_max_hold", 32'(amax), 12);
        chk("init_ctr4", 32'(ctr), 4);

        // Search phase: excursion 120,300,250 ended by 80
        search_en = 1'b1; thr = 11'd100;
        idle();
        send(11'sd50);
        chk("s_below_state", 32'(state), 0);
        chk("s_below_found", 32'(found), 0);
        send(11'sd120);
        chk("s_above_state", 32'(state), 1);
        chk("s_max_frozen", 32'(amax), 12);
        send(11'sd300);
        chk("s_no_early_pulse", 32'(found), 0);
        send(11'sd250);
        chk("s_no_early_pulse2", 32'(found), 0);
        send(11'sd80);
        chk("s_pulse", 32'(found), 1);
        chk("s_peak_max", 32'(amax), 300);
        chk("s_peak_ctr", 32'(peak_ctr), 6);
        idle();
        chk("s_pulse_one_cycle", 32'(found), 0);
        chk("s_refract_state", 32'(state), 2);
        chk("s_peak_hold", 32'(amax), 300);

        // Refractory samples are ignored even above threshold
        send(11'sd500);
        send(11'sd500);
        chk("r_still_refract", 32'(state), 2);
        send(11'sd500);
        chk("r_back_idle", 32'(state), 0);
        chk("r_no_pulse", 32'(found), 0);
        chk("r_max_hold", 32'(amax), 300);

        // Window limit: fourth above-threshold sample closes the excursion
        thr = 11'd10;
        send(11'sd20);
        send(11'sd30);
        send(11'sd40);
        chk("w_no_pulse_yet", 32'(found), 0);
        send(11'sd50);
        chk("w_pulse", 32'(found), 1);
        chk("w_max", 32'(amax), 50);
        chk("w_peak_ctr", 32'(peak_ctr), 15);
        send(11'sd60);
        chk("w_60_no_pulse", 32'(found), 0);
        chk("w_60_refract", 32'(state), 2);
        send(11'sd200);
        send(11'sd200);
        chk("w_refract_done", 32'(state), 0);
        send(11'sd200);
        chk("w_new_excursion", 32'(state), 1);

        // Search enable dropped mid-excursion: abort, and init phase is not re-entered
        @(negedge clk);
        search_en = 1'b0;
        idle();
        chk("abort_state", 32'(state), 0);
        chk("abort_found", 32'(found), 0);
        send(11'sd700);
        chk("abort_max_hold", 32'(amax), 50);
        chk("abort_state2", 32'(state), 0);

        // Sample equal to threshold does not start an excursion
        search_en = 1'b1; thr = 11'd100;
        send(11'sd100);
        chk("eq_thr_state", 32'(state), 0);
        chk("eq_ctr", 32'(ctr), exp_ctr);

        // Valid without clock enable is not accepted
        @(negedge clk);
        sample = 11'sd500; sample_valid = 1'b1; ce = 1'b0;
        @(negedge clk);
        sample_valid = 1'b0; ce = 1'b1;
        chk("ce0_ctr", 32'(ctr), exp_ctr);
        chk("ce0_state", 32'(state), 0);

        // Counter wrap on the 4-bit instance
        while ((exp_ctr % 16) != 15) send(11'sd0);
        chk("wrap_pre", 32'(w_ctr), 15);
        send(11'sd0);
        chk("wrap_zero", 32'(w_ctr), 0);
        send(11'sd0);
        chk("wrap_one", 32'(w_ctr), 1);
        chk("wide_ctr", 32'(ctr), exp_ctr);

        // Reset during refractory clears everything
        thr = 11'd10;
        send(11'sd50);
        chk("rr_above", 32'(state), 1);
        send(11'sd5);
        chk("rr_pulse", 32'(found), 1);
        chk("rr_peak_ctr", 32'(peak_ctr), exp_ctr - 2);
        idle();
        chk("rr_refract", 32'(state), 2);
        rst = 1'b1;
        #1;
        chk("rr_ctr", 32'(ctr), 0);
        chk("rr_max", 32'(amax), 0);
        chk("rr_valid", 32'(avalid), 0);
        chk("rr_peak_ctr0", 32'(peak_ctr), 0);
        chk("rr_state", 32'(state), 0);
        @(negedge clk);
        rst = 1'b0;
        idle();
        chk("rr_found_after", 32'(found), 0);
        chk("rr_state_after", 32'(state), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
